// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the pipelined adder: default geometry and opcode encodings.
// The signed-overflow output is enabled at build time with PIPE_ADDER_OVF_EN.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_STAGE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int num_stages(input int width, input int stage_w);
    return width / stage_w;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple-carry adder; one instance per pipeline stage.
// Exposes the carry into its MSB so the final stage can form signed overflow.
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic         cmsb_o
`endif
);

  logic [W:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
  end

  assign cout_o = c[W];
`ifdef PIPE_ADDER_OVF_EN
  assign cmsb_o = c[W-1];
`endif

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/sub, one STAGE_W chunk per stage, latency STAGES cycles, one op per cycle.
// Whole pipe advances only when the output is empty or taken; ovf port needs PIPE_ADDER_OVF_EN.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int STAGE_W = DEF_STAGE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = num_stages(WIDTH, STAGE_W);

  if ((WIDTH % STAGE_W) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGE_W");
  end

  logic              adv;
  logic [WIDTH-1:0]  eff_b;
  logic              eff_c;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] ch_co;

  // Operand registers hold only the slices still to be added, shifted down so the
  // next chunk always sits in the low bits; the sum fills in from the top.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

`ifdef PIPE_ADDER_OVF_EN
  logic [STAGES-1:0] ch_cm;
  logic              ovf_q, ovf_d;
`endif

  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1; cin is ignored in that case.
  assign eff_b = (sub == OP_SUB) ? ~b : b;
  assign eff_c = (sub == OP_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0]   prv_a, prv_b, prv_sum;
    logic               prv_c, prv_vld;
    logic [STAGE_W-1:0] ch_s;
    logic [WIDTH-1:0]   ch_s_ext;

    if (k == 0) begin : g_head
      assign prv_a   = a;
      assign prv_b   = eff_b;
      assign prv_sum = '0;
      assign prv_c   = eff_c;
      assign prv_vld = in_valid;
    end else begin : g_body
      assign prv_a   = a_q[k-1];
      assign prv_b   = b_q[k-1];
      assign prv_sum = sum_q[k-1];
      assign prv_c   = carry_q[k-1];
      assign prv_vld = vld_q[k-1];
    end

    adder_chunk #(
      .W (STAGE_W)
    ) u_chunk (
      .a_i    (prv_a[STAGE_W-1:0]),
      .b_i    (prv_b[STAGE_W-1:0]),
      .c_i    (prv_c),
      .sum_o  (ch_s),
      .cout_o (ch_co[k])
`ifdef PIPE_ADDER_OVF_EN
      ,
      .cmsb_o (ch_cm[k])
`endif
    );

    assign ch_s_ext   = WIDTH'(ch_s);
    assign a_d[k]     = prv_a >> STAGE_W;
    assign b_d[k]     = prv_b >> STAGE_W;
    assign sum_d[k]   = (prv_sum >> STAGE_W) | (ch_s_ext << (WIDTH - STAGE_W));
    assign carry_d[k] = ch_co[k];
    assign vld_d[k]   = prv_vld;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q   <= vld_d;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  // Signed overflow: carry into MSB differs from carry out of MSB, final chunk only.
  assign ovf_d = ch_cm[STAGES-1] ^ ch_co[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGE_W=4): directed vectors, stalls, resets.
module tb_pipelined_adder;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PIPE_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;

  logic         stalled_prev = 1'b0;
  logic [W-1:0] held_sum;
  logic         held_cout;
  logic         held_ovf;

  // Directed vectors: a, b, cin, sub -> sum, cout, ovf
  logic [W-1:0] va [7] = '{16'h0005, 16'h0007, 16'h0007, 16'h7FFF, 16'h0FFF, 16'h8000, 16'h0000};
  logic [W-1:0] vb [7] = '{16'h0007, 16'h0005, 16'h0005, 16'h0001, 16'h0001, 16'h0001, 16'h0000};
  logic         vc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic         vs [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] vx [7] = '{16'hFFFE, 16'h0002, 16'h0002, 16'h8000, 16'h1001, 16'h7FFF, 16'h0000};
  logic         vo [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic         vv [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  pipelined_adder #(
    .WIDTH   (16),
    .STAGE_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic check16(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, got, want);
    end
  endtask

  task automatic send(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                      input logic op_c, input logic op_s,
                      input logic [W-1:0] es, input logic ec, input logic eo,
                      input bit push);
    int waited;
    @(negedge clk);
    a        = op_a;
    b        = op_b;
    cin      = op_c;
    sub      = op_s;
    in_valid = 1'b1;
    if (push) sb.push_back('{sum: es, cout: ec, ovf: eo});
    #1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, expected 1", waited);
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  // Monitor: pops on every output handshake and checks stability across stalls.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (stalled_prev) begin
        check1("hold_valid", out_valid, 1'b1);
        check16("hold_sum", sum, held_sum);
        check1("hold_cout", cout, held_cout);
`ifdef PIPE_ADDER_OVF_EN
        check1("hold_ovf", ovf, held_ovf);
`endif
      end
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got sum 0x%04h, expected no result", sum);
        end else begin
          e = sb.pop_front();
          check16("sum", sum, e.sum);
          check1("cout", cout, e.cout);
`ifdef PIPE_ADDER_OVF_EN
          check1("ovf", ovf, e.ovf);
`endif
        end
      end
      stalled_prev = rst_n && out_valid && !out_ready;
      held_sum     = sum;
      held_cout    = cout;
`ifdef PIPE_ADDER_OVF_EN
      held_ovf     = ovf;
`else
      held_ovf     = 1'b0;
`endif
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check1("reset_out_valid", out_valid, 1'b0);
    check16("reset_sum", sum, 16'h0000);
    check1("reset_cout", cout, 1'b0);
    check1("reset_in_ready", in_ready, 1'b1);
`ifdef PIPE_ADDER_OVF_EN
    check1("reset_ovf", ovf, 1'b0);
`endif

    // Single op through an empty pipe: result visible after the 4th edge.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    check16("latency", 16'(lat), 16'd4);
    drain();

    for (int i = 0; i < 7; i++) send(va[i], vb[i], vc[i], vs[i], vx[i], vo[i], vv[i], 1'b1);
    drain();

    // Back-to-back stream with a 3-cycle output stall in the middle.
    fork
      begin
        for (int i = 1; i <= 8; i++)
          send(16'(i), 16'(i * 3), 1'b0, 1'b0, 16'(i * 4), 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        check1("stall_out_valid", out_valid, 1'b1);
        check1("stall_in_ready", in_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Three ops in flight, then reset: none may ever emerge.
    for (int i = 0; i < 3; i++)
      send(16'(16'h1000 + i), 16'h0101, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check1("flight_rst_out_valid", out_valid, 1'b0);
    check16("flight_rst_sum", sum, 16'h0000);
    check1("flight_rst_cout", cout, 1'b0);
    check1("flight_rst_in_ready", in_ready, 1'b1);
    repeat (8) @(negedge clk);

    // Result parked at a stalled output, then reset.
    out_ready = 1'b0;
    send(16'h00AA, 16'h0055, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check1("park_out_valid", out_valid, 1'b1);
    check1("park_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check1("park_rst_out_valid", out_valid, 1'b0);
    check16("park_rst_sum", sum, 16'h0000);
    repeat (6) @(negedge clk);

    send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);
    drain();
    repeat (10) @(negedge clk);
    check16("scoreboard_empty", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
